// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle control sequencer for the RV32IM core: steps the shared datapath
// through FETCH/DECODE/EXEC/MEM/MDIV/WB and keeps cycle/retired counters.
module rv32_mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  input  logic [6:0]       op,
  input  logic [9:0]       func,
  input  logic [4:0]       rd,
  input  logic             br_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             md_done,
  output logic             imem_req,
  output logic             ir_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_src_imm,
  output logic             md_start,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned OP_W  = 7;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_REG  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IMM  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_ST   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BR   = 7'b1100011;
  localparam logic [OP_W-1:0] OP_LUI  = 7'b0110111;
  localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR = 7'b1100111;

  localparam logic [SEL_W-1:0] WB_ALU = 2'b00;
  localparam logic [SEL_W-1:0] WB_LD  = 2'b01;
  localparam logic [SEL_W-1:0] WB_PC4 = 2'b10;
  localparam logic [SEL_W-1:0] WB_MD  = 2'b11;

  localparam logic [SEL_W-1:0] PC_SEQ  = 2'b00;
  localparam logic [SEL_W-1:0] PC_BR   = 2'b01;
  localparam logic [SEL_W-1:0] PC_JAL  = 2'b10;
  localparam logic [SEL_W-1:0] PC_JALR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MDIV, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_M, C_I, C_LD, C_S, C_B, C_LUI, C_JAL, C_JALR, C_ILL
  } cls_t;

  state_t state_q, state_d;
  cls_t   cls_q, cls_d, dec_cls;

  logic             imem_req_d, dmem_req_d, dmem_we_d, alu_src_imm_d;
  logic             md_start_d, rf_we_d, pc_en_d, illegal_d;
  logic [SEL_W-1:0] wb_sel_d, pc_sel_d;
  logic [6:0]       funct7;
  logic             unused_funct3;

  assign funct7 = func[9:3];
  // funct3 only steers the datapath, never the sequencing
  assign unused_funct3 = ^func[2:0];

  function automatic logic uses_imm(input cls_t c);
    return (c == C_I) || (c == C_LD) || (c == C_S) || (c == C_LUI) || (c == C_JALR);
  endfunction

  function automatic logic writes_rd(input cls_t c);
    return (c == C_R) || (c == C_M) || (c == C_I) || (c == C_LD) ||
           (c == C_LUI) || (c == C_JAL) || (c == C_JALR);
  endfunction

  // Instruction class from the decoder fields
  always_comb begin
    dec_cls = C_ILL;
    case (op)
      OP_REG: begin
        if ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) dec_cls = C_R;
        else if (funct7 == 7'b0000001)                        dec_cls = C_M;
        else                                                  dec_cls = C_ILL;
      end
      OP_IMM:  dec_cls = C_I;
      OP_LD:   dec_cls = C_LD;
      OP_ST:   dec_cls = C_S;
      OP_BR:   dec_cls = C_B;
      OP_LUI:  dec_cls = C_LUI;
      OP_JAL:  dec_cls = C_JAL;
      OP_JALR: dec_cls = C_JALR;
      default: dec_cls = C_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, plus the Moore outputs of the state being entered so they can be registered
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    imem_req_d    = 1'b0;
    dmem_req_d    = 1'b0;
    dmem_we_d     = 1'b0;
    alu_src_imm_d = 1'b0;
    md_start_d    = 1'b0;
    rf_we_d       = 1'b0;
    wb_sel_d      = WB_ALU;
    pc_en_d       = 1'b0;
    pc_sel_d      = PC_SEQ;
    illegal_d     = illegal;

    case (state_q)
      S_IDLE:   if (!halt) state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == C_ILL)    state_d = S_TRAP;
        else if (dec_cls == C_M) state_d = S_MDIV;
        else                     state_d = S_EXEC;
      end
      S_EXEC:   state_d = ((cls_q == C_LD) || (cls_q == C_S)) ? S_MEM : S_WB;
      S_MEM:    if (dmem_ack) state_d = S_WB;
      S_MDIV:   if (md_done) state_d = S_WB;
      S_WB:     state_d = halt ? S_IDLE : S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase

    case (state_d)
      S_FETCH: imem_req_d = 1'b1;
      S_EXEC:  alu_src_imm_d = uses_imm(cls_d);
      S_MEM: begin
        dmem_req_d    = 1'b1;
        dmem_we_d     = (cls_d == C_S);
        alu_src_imm_d = 1'b1;
      end
      S_MDIV:  md_start_d = (state_q == S_DECODE);
      S_WB: begin
        pc_en_d = 1'b1;
        rf_we_d = writes_rd(cls_d) && (rd != '0);
        case (cls_d)
          C_LD:         wb_sel_d = WB_LD;
          C_JAL, C_JALR: wb_sel_d = WB_PC4;
          C_M:          wb_sel_d = WB_MD;
          default:      wb_sel_d = WB_ALU;
        endcase
        case (cls_d)
          C_B:     pc_sel_d = br_taken ? PC_BR : PC_SEQ;
          C_JAL:   pc_sel_d = PC_JAL;
          C_JALR:  pc_sel_d = PC_JALR;
          default: pc_sel_d = PC_SEQ;
        endcase
      end
      S_TRAP:  illegal_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q       <= C_NONE;
      imem_req    <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      alu_src_imm <= 1'b0;
      md_start    <= 1'b0;
      rf_we       <= 1'b0;
      wb_sel      <= WB_ALU;
      pc_en       <= 1'b0;
      pc_sel      <= PC_SEQ;
      illegal     <= 1'b0;
    end else begin
      cls_q       <= cls_d;
      imem_req    <= imem_req_d;
      dmem_req    <= dmem_req_d;
      dmem_we     <= dmem_we_d;
      alu_src_imm <= alu_src_imm_d;
      md_start    <= md_start_d;
      rf_we       <= rf_we_d;
      wb_sel      <= wb_sel_d;
      pc_en       <= pc_en_d;
      pc_sel      <= pc_sel_d;
      illegal     <= illegal_d;
    end
  end

  // IR must capture in the same cycle the fetch completes
  assign ir_en = (state_q == S_FETCH) && imem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state_q == S_WB) instret <= instret + CNT_W'(1);
    end
  end

endmodule
